// File: rtl/corefifo_sync_pkg.sv
// Shared stage limits and Gray/binary helpers for the CoreFIFO pointer synchronizer.
// Helpers work on a fixed wide word; callers zero-extend their pointer and truncate the result.
package corefifo_sync_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_PTR_WIDTH   = 32;

  typedef logic [MAX_PTR_WIDTH-1:0] ptr_word_t;

  // Zero-extended Gray input decodes correctly because the unused top bits stay 0.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int popcount(input ptr_word_t v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_PTR_WIDTH; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/corefifo_sync_chain.sv
// Plain multi-flop synchronizer chain for a bus that changes at most one bit at a time.
module corefifo_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/corefifo_ptr_sync.sv
// Gray pointer synchronizer with binary decode, advance delta and chain-fill tracking.
// Optional Gray-violation checker is enabled by defining CORE_FIFO_GRAY_CHECK_EN.
module corefifo_ptr_sync
  import corefifo_sync_pkg::*;
#(
  parameter int ADDRWIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDRWIDTH:0] gray_in,
  output logic [ADDRWIDTH:0] gray_sync,
  output logic [ADDRWIDTH:0] bin_sync,
  output logic               bin_valid,
  output logic [ADDRWIDTH:0] delta,
  output logic               delta_valid,
  output logic               gray_err
);

  localparam int PW       = ADDRWIDTH + 1;
  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int CW       = $clog2(MAX_SYNC_STAGES + 2);

  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $fatal(1, "corefifo_ptr_sync: SYNC_STAGES must lie in MIN_SYNC_STAGES..MAX_SYNC_STAGES");
  end
  if (PW > MAX_PTR_WIDTH) begin : g_bad_width
    $fatal(1, "corefifo_ptr_sync: ADDRWIDTH+1 exceeds MAX_PTR_WIDTH");
  end

  logic [PW-1:0] w_gray_sync;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_delta_next;
  logic          w_bin_change;
  logic          w_bin_valid;
  logic [PW-1:0] r_bin_sync;
  logic [PW-1:0] r_delta;
  logic          r_delta_valid;
  logic [CW-1:0] r_fill;

  corefifo_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk    (clk),
    .rst    (rst),
    .i_data (gray_in),
    .o_data (w_gray_sync)
  );

  // r_bin_sync doubles as the previous sample, so the delta is taken against it directly.
  assign w_bin_next   = PW'(gray2bin(MAX_PTR_WIDTH'(w_gray_sync)));
  assign w_delta_next = w_bin_next - r_bin_sync;
  assign w_bin_change = (w_bin_next != r_bin_sync);
  assign w_bin_valid  = (r_fill == CW'(FILL_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_sync    <= '0;
      r_delta       <= '0;
      r_delta_valid <= 1'b0;
      r_fill        <= '0;
    end else begin
      r_bin_sync    <= w_bin_next;
      r_delta_valid <= w_bin_valid && w_bin_change;
      if (w_bin_valid && w_bin_change) begin
        r_delta <= w_delta_next;
      end
      if (!w_bin_valid) begin
        r_fill <= r_fill + CW'(1);
      end
    end
  end

`ifdef CORE_FIFO_GRAY_CHECK_EN
  logic [PW-1:0] r_gray_prev;
  logic          r_gray_err;

  // A legal Gray pointer moves one bit per sample; anything more means a broken crossing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray_prev <= '0;
      r_gray_err  <= 1'b0;
    end else begin
      r_gray_prev <= w_gray_sync;
      if (w_bin_valid && popcount(MAX_PTR_WIDTH'(w_gray_sync ^ r_gray_prev)) > 1) begin
        r_gray_err <= 1'b1;
      end
    end
  end

  assign gray_err = r_gray_err;
`else
  assign gray_err = 1'b0;
`endif

  assign gray_sync   = w_gray_sync;
  assign bin_sync    = r_bin_sync;
  assign bin_valid   = w_bin_valid;
  assign delta       = r_delta;
  assign delta_valid = r_delta_valid;

endmodule

// File: tb/tb_corefifo_ptr_sync.sv
// Self-checking bench for corefifo_ptr_sync with 2-stage and 3-stage instances side by side.
// Reference model tracks the history of sampled gray_in values and derives outputs from it.
module tb_corefifo_ptr_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = 4'h0;

  logic [3:0] gs2, bs2, d2;
  logic       bv2, dv2, ge2;
  logic [3:0] gs3, bs3, d3;
  logic       bv3, dv3, ge3;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  corefifo_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .gray_sync   (gs2),
    .bin_sync    (bs2),
    .bin_valid   (bv2),
    .delta       (d2),
    .delta_valid (dv2),
    .gray_err    (ge2)
  );

  corefifo_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .gray_sync   (gs3),
    .bin_sync    (bs3),
    .bin_valid   (bv3),
    .delta       (d3),
    .delta_valid (dv3),
    .gray_err    (ge3)
  );

  function automatic logic [3:0] tbG2B(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] tbB2G(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference model: hist[k] is the gray_in value captured k edges ago (zeros after reset).
  logic [3:0] hist [0:7];
  int         sinceRst;
  logic [3:0] mDelta [2:3];
  logic       mDv    [2:3];
  logic       mErr   [2:3];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) hist[k] = 4'h0;
      sinceRst = 0;
      for (int s = 2; s <= 3; s++) begin
        mDelta[s] = 4'h0;
        mDv[s]    = 1'b0;
        mErr[s]   = 1'b0;
      end
    end else begin
      for (int s = 2; s <= 3; s++) begin
        logic       validBefore;
        logic [3:0] oldBin;
        logic [3:0] newBin;
        validBefore = (sinceRst >= s + 1);
        oldBin      = tbG2B(hist[s]);
        newBin      = tbG2B(hist[s-1]);
        mDv[s]      = validBefore && (newBin != oldBin);
        if (mDv[s]) mDelta[s] = newBin - oldBin;
`ifdef CORE_FIFO_GRAY_CHECK_EN
        if (validBefore && $countones(hist[s-1] ^ hist[s]) > 1) mErr[s] = 1'b1;
`endif
      end
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = gray_in;
      if (sinceRst < 1000) sinceRst++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gray_in = 4'h0;
    repeat (3) tick();
    nCompared++;
    if ({gs2, bs2, bv2, d2, dv2, ge2} !== 15'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_s2: got %h expected 0000", {gs2, bs2, bv2, d2, dv2, ge2});
    end
    nCompared++;
    if ({gs3, bs3, bv3, d3, dv3, ge3} !== 15'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_s3: got %h expected 0000", {gs3, bs3, bv3, d3, dv3, ge3});
    end
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      nCompared++;
      if (bv2 !== (e >= 3)) begin
        nMismatched++;
        $display("[TB] FAIL fill_bv2 edge %0d: got %b expected %b", e, bv2, (e >= 3));
      end
      nCompared++;
      if (bv3 !== (e >= 4)) begin
        nMismatched++;
        $display("[TB] FAIL fill_bv3 edge %0d: got %b expected %b", e, bv3, (e >= 4));
      end
      nCompared++;
      if ({dv2, dv3} !== 2'b00) begin
        nMismatched++;
        $display("[TB] FAIL fill_dv edge %0d: got %b expected 00", e, {dv2, dv3});
      end
    end
  endtask

  task automatic test_increment();
    for (int b = 1; b <= 5; b++) begin
      gray_in = tbB2G(4'(b));
      for (int e = 1; e <= 4; e++) begin
        tick();
        nCompared++;
        if (bs3 !== 4'(e >= 4 ? b : b - 1) || dv3 !== (e == 4)) begin
          nMismatched++;
          $display("[TB] FAIL inc_s3 step %0d edge %0d: got bin=%h dv=%b expected bin=%h dv=%b",
                   b, e, bs3, dv3, 4'(e >= 4 ? b : b - 1), (e == 4));
        end
        nCompared++;
        if (bs2 !== 4'(e >= 3 ? b : b - 1) || dv2 !== (e == 3)) begin
          nMismatched++;
          $display("[TB] FAIL inc_s2 step %0d edge %0d: got bin=%h dv=%b expected bin=%h dv=%b",
                   b, e, bs2, dv2, 4'(e >= 3 ? b : b - 1), (e == 3));
        end
        if (e == 4) begin
          nCompared++;
          if (d3 !== 4'h1) begin
            nMismatched++;
            $display("[TB] FAIL inc_delta step %0d: got %h expected 1", b, d3);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int expBin;
    gray_in = tbB2G(4'd4);
    repeat (5) tick();
    for (int e = 1; e <= 8; e++) begin
      if (e <= 3) gray_in = tbB2G(4'(4 + e));
      tick();
      expBin = 4 + ((e <= 3) ? 0 : (e >= 6) ? 3 : e - 3);
      nCompared++;
      if (bs3 !== 4'(expBin) || dv3 !== (e >= 4 && e <= 6)) begin
        nMismatched++;
        $display("[TB] FAIL burst_s3 edge %0d: got bin=%h dv=%b expected bin=%h dv=%b",
                 e, bs3, dv3, 4'(expBin), (e >= 4 && e <= 6));
      end
      nCompared++;
      if (dv2 !== (e >= 3 && e <= 5)) begin
        nMismatched++;
        $display("[TB] FAIL burst_dv2 edge %0d: got %b expected %b", e, dv2, (e >= 3 && e <= 5));
      end
      if (e >= 4 && e <= 6) begin
        nCompared++;
        if (d3 !== 4'h1) begin
          nMismatched++;
          $display("[TB] FAIL burst_delta edge %0d: got %h expected 1", e, d3);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int v = 8; v <= 15; v++) begin
      gray_in = tbB2G(4'(v));
      tick();
    end
    repeat (5) tick();
    gray_in = 4'h0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      nCompared++;
      if (bs3 !== ((e >= 4) ? 4'h0 : 4'hF) || dv3 !== (e == 4)) begin
        nMismatched++;
        $display("[TB] FAIL wrap_s3 edge %0d: got bin=%h dv=%b expected bin=%h dv=%b",
                 e, bs3, dv3, ((e >= 4) ? 4'h0 : 4'hF), (e == 4));
      end
      if (e == 4) begin
        nCompared++;
        if (d3 !== 4'h1) begin
          nMismatched++;
          $display("[TB] FAIL wrap_delta: got %h expected 1", d3);
        end
      end
    end
  endtask

  task automatic test_gray_violation();
    logic expErr3;
    logic expErr2;
    gray_in = 4'h3;
    for (int e = 1; e <= 6; e++) begin
      tick();
`ifdef CORE_FIFO_GRAY_CHECK_EN
      expErr3 = (e >= 4);
      expErr2 = (e >= 3);
`else
      expErr3 = 1'b0;
      expErr2 = 1'b0;
`endif
      nCompared++;
      if (gs3 !== ((e >= 3) ? 4'h3 : 4'h0) || ge3 !== expErr3) begin
        nMismatched++;
        $display("[TB] FAIL viol_s3 edge %0d: got gs=%h err=%b expected gs=%h err=%b",
                 e, gs3, ge3, ((e >= 3) ? 4'h3 : 4'h0), expErr3);
      end
      nCompared++;
      if (ge2 !== expErr2) begin
        nMismatched++;
        $display("[TB] FAIL viol_err2 edge %0d: got %b expected %b", e, ge2, expErr2);
      end
      if (e == 4) begin
        nCompared++;
        if (d3 !== 4'h2 || dv3 !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL viol_delta: got d=%h dv=%b expected d=2 dv=1", d3, dv3);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int v = 3; v <= 6; v++) begin
      gray_in = tbB2G(4'(v));
      tick();
    end
    repeat (5) tick();
    nCompared++;
    if (bs3 !== 4'h6) begin
      nMismatched++;
      $display("[TB] FAIL midrst_pre: got bin=%h expected 6", bs3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nCompared++;
    if ({gs2, bs2, bv2, d2, dv2, ge2} !== 15'h0) begin
      nMismatched++;
      $display("[TB] FAIL midrst_s2: got %h expected 0000", {gs2, bs2, bv2, d2, dv2, ge2});
    end
    nCompared++;
    if ({gs3, bs3, bv3, d3, dv3, ge3} !== 15'h0) begin
      nMismatched++;
      $display("[TB] FAIL midrst_s3: got %h expected 0000", {gs3, bs3, bv3, d3, dv3, ge3});
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      nCompared++;
      if (bv3 !== (e >= 4) || bv2 !== (e >= 3) || {dv2, dv3} !== 2'b00) begin
        nMismatched++;
        $display("[TB] FAIL refill edge %0d: got bv2=%b bv3=%b dv=%b expected bv2=%b bv3=%b dv=00",
                 e, bv2, bv3, {dv2, dv3}, (e >= 3), (e >= 4));
      end
    end
    nCompared++;
    if (bs3 !== 4'h6 || d3 !== 4'h0) begin
      nMismatched++;
      $display("[TB] FAIL refill_hold: got bin=%h delta=%h expected bin=6 delta=0", bs3, d3);
    end
  endtask

  task automatic test_random();
    logic [3:0] curBin;
    int         r;
    curBin = 4'h6;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2);
      if (r >= 2 && r < 5) begin
        gray_in = 4'($urandom_range(0, 15));
        curBin  = tbG2B(gray_in);
      end else if (r < 50) begin
        curBin  = curBin + 4'h1;
        gray_in = tbB2G(curBin);
      end else if (r < 65) begin
        curBin  = curBin - 4'h1;
        gray_in = tbB2G(curBin);
      end
      tick();
      nCompared++;
      if ({gs2, bs2, bv2, d2, dv2, ge2} !==
          {hist[1], tbG2B(hist[2]), (sinceRst >= 3), mDelta[2], mDv[2], mErr[2]}) begin
        nMismatched++;
        $display("[TB] FAIL rand_s2 cycle %0d: got gs=%h bs=%h bv=%b d=%h dv=%b ge=%b expected gs=%h bs=%h bv=%b d=%h dv=%b ge=%b",
                 c, gs2, bs2, bv2, d2, dv2, ge2,
                 hist[1], tbG2B(hist[2]), (sinceRst >= 3), mDelta[2], mDv[2], mErr[2]);
      end
      nCompared++;
      if ({gs3, bs3, bv3, d3, dv3, ge3} !==
          {hist[2], tbG2B(hist[3]), (sinceRst >= 4), mDelta[3], mDv[3], mErr[3]}) begin
        nMismatched++;
        $display("[TB] FAIL rand_s3 cycle %0d: got gs=%h bs=%h bv=%b d=%h dv=%b ge=%b expected gs=%h bs=%h bv=%b d=%h dv=%b ge=%b",
                 c, gs3, bs3, bv3, d3, dv3, ge3,
                 hist[2], tbG2B(hist[3]), (sinceRst >= 4), mDelta[3], mDv[3], mErr[3]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] corefifo_ptr_sync bench starting");
    test_reset();
    test_increment();
    test_back_to_back();
    test_wrap();
    test_gray_violation();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
